// File: rtl/key_conditioner.sv
// Push-button front end: per-key two-flop synchroniser, debounce FSM and
// auto-repeat timer producing a stable level plus press/release/repeat strobes.
//
// state    | meaning
// ST_REL   | key released and stable, key_level = 0
// ST_PWAIT | raw key looks pressed, counting stable cycles before accepting
// ST_HELD  | key pressed and stable, key_level = 1, repeat timer running
// ST_RWAIT | raw key looks released, counting stable cycles; repeat timer frozen
module key_conditioner #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] keys_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat
);

  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(RMAX + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] T_DELAY  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] T_PERIOD = TW'(REPEAT_PERIOD - 1);
  localparam bit            REP_EN   = (REPEAT_DELAY > 0);

  typedef enum logic [1:0] {
    ST_REL   = 2'd0,
    ST_PWAIT = 2'd1,
    ST_HELD  = 2'd2,
    ST_RWAIT = 2'd3
  } state_t;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    logic          sync1_q, sync1_d, sync2_q, sync2_d;
    logic          s;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          repeat_q, repeat_d;

    // Synchroniser resets to "released" so a key held through reset is seen as a new press.
    assign s = ~sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q   <= 1'b1;
        sync2_q   <= 1'b1;
        state_q   <= ST_REL;
        cnt_q     <= '0;
        tmr_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        sync1_q   <= sync1_d;
        sync2_q   <= sync2_d;
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        tmr_q     <= tmr_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
        repeat_q  <= repeat_d;
      end
    end

    always_comb begin
      sync1_d   = keys_n[g];
      sync2_d   = sync1_q;
      state_d   = state_q;
      cnt_d     = cnt_q;
      tmr_d     = tmr_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      repeat_d  = 1'b0;
      case (state_q)
        ST_REL: begin
          tmr_d = '0;
          if (s) begin
            state_d = ST_PWAIT;
            cnt_d   = '0;
          end
        end
        ST_PWAIT: begin
          if (!s) begin
            state_d = ST_REL;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_HELD;
            press_d = 1'b1;
            tmr_d   = REP_EN ? T_DELAY : '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_HELD: begin
          if (REP_EN) begin
            if (tmr_q == '0) begin
              repeat_d = 1'b1;
              tmr_d    = T_PERIOD;
            end else begin
              tmr_d = tmr_q - TW'(1);
            end
          end
          if (!s) begin
            state_d = ST_RWAIT;
            cnt_d   = '0;
          end
        end
        ST_RWAIT: begin
          if (s) begin
            state_d = ST_HELD;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = ST_REL;
            release_d = 1'b1;
            tmr_d     = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = ST_REL;
      endcase
      level_d = (state_d == ST_HELD) || (state_d == ST_RWAIT);
    end

    assign key_level[g]   = level_q;
    assign key_press[g]   = press_q;
    assign key_release[g] = release_q;
    assign key_repeat[g]  = repeat_q;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3).
// Edge e counts rising edges after the stimulus change; outputs are sampled 1 time unit later.
module tb_key_conditioner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] keys_n = 4'hF;
  logic [3:0] key_level, key_press, key_release, key_repeat;
  logic [3:0] exp_lv, exp_pr, exp_rl, exp_rp;
  int         total = 0;
  int         bad = 0;

  key_conditioner #(
    .N_KEYS(4),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .keys_n(keys_n),
    .key_level(key_level),
    .key_press(key_press),
    .key_release(key_release),
    .key_repeat(key_repeat)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int e);
    check_val($sformatf("%s level e%0d", tag, e),   {28'd0, key_level},   {28'd0, exp_lv});
    check_val($sformatf("%s press e%0d", tag, e),   {28'd0, key_press},   {28'd0, exp_pr});
    check_val($sformatf("%s release e%0d", tag, e), {28'd0, key_release}, {28'd0, exp_rl});
    check_val($sformatf("%s repeat e%0d", tag, e),  {28'd0, key_repeat},  {28'd0, exp_rp});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_idle;
    exp_lv = '0; exp_pr = '0; exp_rl = '0; exp_rp = '0;
  endtask

  initial begin
    // reset: outputs low during and after reset
    expect_idle();
    for (int e = 0; e < 3; e++) begin
      tick();
      check_outs("rst_hold", e);
    end
    rst_n = 1'b1;
    for (int e = 0; e < 20; e++) begin
      tick();
      check_outs("rst_idle", e);
    end

    // clean press/release on key 0: press at 6, release driven at edge 8 -> strobe at 14
    keys_n[0] = 1'b0;
    for (int e = 0; e <= 20; e++) begin
      tick();
      if (e == 7) keys_n[0] = 1'b1;
      expect_idle();
      exp_lv[0] = (e >= 6) && (e < 14);
      exp_pr[0] = (e == 6);
      exp_rl[0] = (e == 14);
      check_outs("clean", e);
    end

    // bounce on key 1: alternating every cycle, never accepted
    for (int k = 0; k < 20; k++) begin
      keys_n[1] = (k % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      expect_idle();
      check_outs("bounce", k);
    end
    keys_n[1] = 1'b1;
    for (int e = 0; e < 5; e++) begin
      tick();
      check_outs("bounce_idle", e);
    end
    keys_n[1] = 1'b0;
    for (int e = 0; e <= 9; e++) begin
      tick();
      expect_idle();
      exp_lv[1] = (e >= 6);
      exp_pr[1] = (e == 6);
      check_outs("bounce_press", e);
    end
    keys_n[1] = 1'b1;
    for (int e = 0; e <= 9; e++) begin
      tick();
      expect_idle();
      exp_lv[1] = (e < 6);
      exp_rl[1] = (e == 6);
      check_outs("bounce_rel", e);
    end

    // auto-repeat on key 2: held 40 edges, repeats at 16,19,...,40, release at 46
    keys_n[2] = 1'b0;
    for (int e = 0; e <= 55; e++) begin
      tick();
      if (e == 39) keys_n[2] = 1'b1;
      expect_idle();
      exp_lv[2] = (e >= 6) && (e <= 45);
      exp_pr[2] = (e == 6);
      exp_rl[2] = (e == 46);
      exp_rp[2] = (e >= 16) && (e <= 40) && ((e - 16) % 3 == 0);
      check_outs("repeat", e);
    end

    // release bounce on key 3 during hold: two RWAIT cycles shift repeats by 2
    keys_n[3] = 1'b0;
    for (int e = 0; e <= 44; e++) begin
      tick();
      if (e == 17) keys_n[3] = 1'b1;
      if (e == 19) keys_n[3] = 1'b0;
      if (e == 31) keys_n[3] = 1'b1;
      expect_idle();
      exp_lv[3] = (e >= 6) && (e <= 37);
      exp_pr[3] = (e == 6);
      exp_rl[3] = (e == 38);
      exp_rp[3] = (e == 16) || (e == 19) || (e == 24) || (e == 27) || (e == 30) || (e == 33);
      check_outs("rbounce", e);
    end

    // simultaneous press on all keys, reset asserted while repeat strobes are high
    keys_n = 4'h0;
    for (int e = 0; e <= 16; e++) begin
      tick();
      expect_idle();
      exp_lv = (e >= 6) ? 4'hF : 4'h0;
      exp_pr = (e == 6) ? 4'hF : 4'h0;
      exp_rp = (e == 16) ? 4'hF : 4'h0;
      check_outs("simul", e);
    end
    rst_n = 1'b0;
    #1;
    expect_idle();
    check_outs("rst_mid_repeat", 0);
    keys_n = 4'b1110;
    tick();
    tick();
    check_outs("rst_mid_repeat", 1);
    rst_n = 1'b1;
    for (int e = 0; e <= 3; e++) begin
      tick();
      check_outs("pwait", e);
    end

    // reset mid-PWAIT with key 0 still held: press re-reported 6 edges after release
    rst_n = 1'b0;
    #1;
    check_outs("rst_mid_pwait", 0);
    tick();
    tick();
    check_outs("rst_mid_pwait", 1);
    rst_n = 1'b1;
    for (int e = 0; e <= 9; e++) begin
      tick();
      expect_idle();
      exp_lv[0] = (e >= 6);
      exp_pr[0] = (e == 6);
      check_outs("repress", e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Synchronous front end for the board push-buttons (KEY[3:0], active-low) that feed the vending-machine control logic. Each raw key is synchronised, debounced and converted into a stable level plus single-cycle press, release and auto-repeat strobes, all in the `clk` domain. Downstream logic (coin insert, confirm/change, display toggle) consumes these strobes instead of clocking on raw key edges.

## Interface
Parameters:
- `N_KEYS`, 4: number of independent key channels.
- `DEBOUNCE_CYCLES`, 1000000: consecutive stable cycles required to accept a level change (20 ms at 50 MHz). Must be ≥ 1.
- `REPEAT_DELAY`, 25000000: cycles from a press strobe to the first repeat strobe. A value of 0 disables auto-repeat.
- `REPEAT_PERIOD`, 5000000: cycles between subsequent repeat strobes. Must be ≥ 1.

Ports:
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `keys_n`, input, N_KEYS: raw key inputs, asynchronous. 0 = pressed.
- `key_level`, output, N_KEYS: debounced state. 1 = pressed.
- `key_press`, output, N_KEYS: one-cycle strobe when the debounced state becomes pressed.
- `key_release`, output, N_KEYS: one-cycle strobe when the debounced state becomes released.
- `key_repeat`, output, N_KEYS: one-cycle auto-repeat strobe while a key is held.

## Operation
The channels are fully independent. Each channel contains the following elements.

- **Synchroniser.** Two flip-flops, reset to 1 (released). The output `s` is the raw level inverted, so 1 means pressed.
- **Debounce FSM.** Reset state is REL.
  - REL: `key_level`=0. If `s`=1, go to PWAIT and clear the counter.
  - PWAIT: If `s`=0, return to REL. Otherwise increment the counter. When the counter reaches DEBOUNCE_CYCLES−1 and `s`=1, go to HELD and assert `key_press` for one cycle.
  - HELD: `key_level`=1. If `s`=0, go to RWAIT and clear the counter.
  - RWAIT: `key_level` stays 1. If `s`=1, return to HELD. Otherwise increment the counter. At DEBOUNCE_CYCLES−1 with `s`=0, go to REL and assert `key_release` for one cycle.
  - Any mismatch during a WAIT state returns to the previous stable state with no strobe, which filters bounce.
- **Debounce counter width.** `$clog2(DEBOUNCE_CYCLES+1)` bits. The counter is cleared on every entry to a WAIT state, so it never wraps.
- **Repeat timer.**
  - The timer loads REPEAT_DELAY−1 on the `key_press` cycle and counts down only in HELD.
  - While in RWAIT the timer freezes, and it resumes if the FSM returns to HELD.
  - When it reaches 0 in HELD, `key_repeat` is asserted for one cycle and the timer reloads REPEAT_PERIOD−1.
  - Entering REL clears the timer.
  - If REPEAT_DELAY=0, `key_repeat` is tied to 0.
  - Timer width is `$clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1)` bits.
- **Strobe exclusivity.** `key_press`, `key_release` and `key_repeat` are never high together on the same channel.
- **Registered outputs.** All outputs are registered, with no combinational path from `keys_n`.

## Timing
- **Reset.** `key_level`, `key_press`, `key_release` and `key_repeat` are all 0. Synchronisers are 1, FSMs are in REL, and counters are 0. Reset asserted mid-operation, including mid-WAIT or mid-repeat, forces this state immediately with no strobe.
- **Key held through reset release.** This is reported as a genuine press after the normal latency.
- **Press latency.** Suppose `keys_n` falls and is stable, and the first sampling edge is edge 0. Then `s`=1 after edge 1, and PWAIT is entered at edge 2. `key_press` and `key_level` rise at edge 2+DEBOUNCE_CYCLES. Release latency is identical.
- **Repeat timing.** The first `key_repeat` comes REPEAT_DELAY cycles after the `key_press` cycle. Subsequent strobes come every REPEAT_PERIOD cycles, measured only over HELD cycles; RWAIT cycles are not counted.
- **Glitch rejection.** A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no strobe and no `key_level` change.
- **Simultaneous presses.** Presses on different channels in the same cycle produce strobes in the same cycle.

## Test plan
Unless stated otherwise, all tests use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3 and N_KEYS=4.

1. **Reset.** Assert `rst_n`=0 with `keys_n`=4'b1111, then release reset and idle for 20 cycles. All outputs must stay 0 throughout.
2. **Clean press/release.** Drive `keys_n[0]` low at edge 0. `key_press[0]` must be high only at edge 6, with `key_level[0]` 1 from edge 6. Drive the key high again 8 cycles later. `key_release[0]` must pulse 6 edges after that, and `key_level[0]` must return to 0 at the same edge.
3. **Bounce.** Toggle `keys_n[1]` low/high with a 2-cycle period for 20 cycles, then leave it high. There must be no strobes and `key_level[1]` must stay 0. Then drive it low steadily: exactly one `key_press[1]` must follow, 6 edges later.
4. **Auto-repeat.** Hold `keys_n[2]` low for 40 cycles. `key_press[2]` occurs at cycle P. `key_repeat[2]` must occur at P+10, P+13, P+16 and so on until the key is released. No repeat may be issued after `key_release[2]`.
5. **Release bounce during hold.** While key 3 is held, pulse `keys_n[3]` high for 2 cycles. There must be no `key_release[3]`, `key_level[3]` must stay 1, and the repeat schedule must shift by exactly 2 cycles.
6. **Simultaneous and reset mid-op.** Press all four keys on the same edge; all `key_press` bits must pulse on the same cycle. Then assert `rst_n` mid-PWAIT: all outputs must be 0 immediately, and a still-held key must re-report `key_press` 6 edges after reset is released.
